// File: rtl/apb_to_axi_lite.sv
// APB4 completer that forwards each in-window transfer as a single AXI4-Lite
// transaction. Out-of-window transfers are answered locally with pslverr.
module apb_to_axi_lite #(
  parameter int unsigned          AddrWidth  = 32,
  parameter int unsigned          DataWidth  = 32,
  parameter logic [AddrWidth-1:0] BaseAddr   = 32'h0000_0000,
  parameter logic [AddrWidth-1:0] WindowSize = 32'h0010_0000,
  localparam int unsigned         StrbWidth  = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // APB4 completer
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [2:0]           pprot_i,
  input  logic [DataWidth-1:0] pwdata_i,
  input  logic [StrbWidth-1:0] pstrb_i,
  output logic                 pready_o,
  output logic [DataWidth-1:0] prdata_o,
  output logic                 pslverr_o,
  // AXI4-Lite write address
  output logic [AddrWidth-1:0] aw_addr_o,
  output logic [2:0]           aw_prot_o,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  // AXI4-Lite write data
  output logic [DataWidth-1:0] w_data_o,
  output logic [StrbWidth-1:0] w_strb_o,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  // AXI4-Lite write response
  input  logic [1:0]           b_resp_i,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  // AXI4-Lite read address
  output logic [AddrWidth-1:0] ar_addr_o,
  output logic [2:0]           ar_prot_o,
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  // AXI4-Lite read data
  input  logic [DataWidth-1:0] r_data_i,
  input  logic [1:0]           r_resp_i,
  input  logic                 r_valid_i,
  output logic                 r_ready_o
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_e;

  // One extra bit so BaseAddr + WindowSize cannot wrap at the top of memory.
  localparam logic [AddrWidth:0] WinLo = {1'b0, BaseAddr};
  localparam logic [AddrWidth:0] WinHi = {1'b0, BaseAddr} + {1'b0, WindowSize};

  state_e               state_q,    state_d;
  logic [AddrWidth-1:0] addr_q,     addr_d;
  logic [2:0]           prot_q,     prot_d;
  logic [DataWidth-1:0] wdata_q,    wdata_d;
  logic [StrbWidth-1:0] strb_q,     strb_d;
  logic                 aw_valid_q, aw_valid_d;
  logic                 w_valid_q,  w_valid_d;
  logic                 ar_valid_q, ar_valid_d;
  logic                 b_ready_q,  b_ready_d;
  logic                 r_ready_q,  r_ready_d;
  logic                 pready_q,   pready_d;
  logic                 pslverr_q,  pslverr_d;
  logic [DataWidth-1:0] prdata_q,   prdata_d;

  logic in_window;
  assign in_window = ({1'b0, paddr_i} >= WinLo) && ({1'b0, paddr_i} < WinHi);

  // A transfer starts on psel alone, and only bit 1 of a response matters.
  logic unused_inputs;
  assign unused_inputs = ^{penable_i, b_resp_i[0], r_resp_i[0]};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    prot_d     = prot_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    b_ready_d  = 1'b0;
    r_ready_d  = 1'b0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (psel_i) begin
          addr_d  = paddr_i;
          prot_d  = pprot_i;
          wdata_d = pwdata_i;
          strb_d  = pstrb_i;
          if (!in_window) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else if (pwrite_i) begin
            state_d    = WR_REQ;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = RD_REQ;
            ar_valid_d = 1'b1;
          end
        end
      end

      WR_REQ: begin
        // AW and W retire independently; response phase waits for both.
        if (aw_valid_q && aw_ready_i) aw_valid_d = 1'b0;
        if (w_valid_q && w_ready_i)   w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) begin
          state_d   = WR_RESP;
          b_ready_d = 1'b1;
        end
      end

      WR_RESP: begin
        b_ready_d = 1'b1;
        if (b_valid_i && b_ready_q) begin
          b_ready_d = 1'b0;
          pslverr_d = b_resp_i[1];
          pready_d  = 1'b1;
          state_d   = DONE;
        end
      end

      RD_REQ: begin
        if (ar_valid_q && ar_ready_i) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = RD_RESP;
        end
      end

      RD_RESP: begin
        r_ready_d = 1'b1;
        if (r_valid_i && r_ready_q) begin
          r_ready_d = 1'b0;
          prdata_d  = r_data_i;
          pslverr_d = r_resp_i[1];
          pready_d  = 1'b1;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge value of its neighbours, matching the hardware it describes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      prot_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      prot_q     <= prot_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      b_ready_q  <= b_ready_d;
      r_ready_q  <= r_ready_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
    end
  end

  // Both request channels share the latched address; only one is ever valid.
  assign aw_addr_o  = addr_q;
  assign aw_prot_o  = prot_q;
  assign aw_valid_o = aw_valid_q;
  assign w_data_o   = wdata_q;
  assign w_strb_o   = strb_q;
  assign w_valid_o  = w_valid_q;
  assign b_ready_o  = b_ready_q;
  assign ar_addr_o  = addr_q;
  assign ar_prot_o  = prot_q;
  assign ar_valid_o = ar_valid_q;
  assign r_ready_o  = r_ready_q;
  assign pready_o   = pready_q;
  assign pslverr_o  = pslverr_q;
  assign prdata_o   = prdata_q;

endmodule
